hca_arb_4x9: RTL and testbench

HCA_ARB_4X9 -- requirements
Module: hca_arb_4x9

---
 rtl/hca_arb_4x9.sv | 188 ++++++++++++++++++
 tb/tb_hca_arb_4x9.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hca_arb_4x9.sv
// hca_arb_4x9: round-robin arbiter in front of one shared adder.
//   Up to NREQ requesters each offer an operand pair (X, Y). One requester is
//   granted per operation. Its operands go through a single Han-Carlson prefix
//   adder, and the W+1 bit sum is then presented until the consumer accepts it.
// Ports:
//   CLK, RSTn            clock, async active-low reset
//   VALID[NREQ]          requester i has an operand pair on X/Y slice i
//   X, Y[NREQ*W]         packed operands, slice i = [W*i +: W], unsigned
//   CIN[NREQ]            per-requester carry-in, present only with HCA_ARB_CIN_EN
//   READY[NREQ]          one-hot grant; asserted combinationally in IDLE only
//   RES_VALID/RES_READY  result handshake
//   RES_S[W+1], RES_ID   sum (bit W = carry-out) and owning requester
// Build option: define HCA_ARB_CIN_EN to add the CIN port.
module hca_arb_4x9 #(
  parameter int NREQ = 4,
  parameter int W    = 9
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic [NREQ-1:0]       VALID,
  input  logic [NREQ*W-1:0]     X,
  input  logic [NREQ*W-1:0]     Y,
`ifdef HCA_ARB_CIN_EN
  input  logic [NREQ-1:0]       CIN,
`endif
  output logic [NREQ-1:0]       READY,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [W:0]            RES_S,
  output logic [$clog2(NREQ)-1:0] RES_ID
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  x_q, x_d, y_q, y_d;
  logic [PW-1:0] id_q, id_d;
  logic [W:0]    res_s_q, res_s_d;
  logic [PW-1:0] res_id_q, res_id_d;
  logic          cin_w;

  // Round-robin pick: first VALID starting just after the last grant.
  logic          gnt_found;
  logic [PW-1:0] gnt_idx, cand;
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr_q + PW'(k);
      if (!gnt_found && VALID[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  logic [W-1:0] x_sel, y_sel;
  logic         cin_sel;
  always_comb begin
    x_sel   = '0;
    y_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == gnt_idx) begin
        x_sel = X[i*W +: W];
        y_sel = Y[i*W +: W];
`ifdef HCA_ARB_CIN_EN
        cin_sel = CIN[i];
`endif
      end
    end
  end

`ifdef HCA_ARB_CIN_EN
  logic cin_q, cin_d;
  assign cin_w = cin_q;
`else
  assign cin_w = 1'b0;
`endif

  // Han-Carlson prefix adder: odd bits pair with their even neighbour, then
  // Kogge-Stone runs on odd bits only, and one last level fills in even bits.
  // Carry-in is folded into bit 0's generate so gg[i] is the carry out of bit i.
  logic [W-1:0] g, p, gg, pp, ng, np;
  logic [W:0]   sum;
  always_comb begin
    g    = x_q & y_q;
    p    = x_q ^ y_q;
    g[0] = g[0] | (p[0] & cin_w);
    gg   = g;
    pp   = p;
    for (int i = 1; i < W; i += 2) begin
      gg[i] = g[i] | (p[i] & g[i-1]);
      pp[i] = p[i] & p[i-1];
    end
    for (int d = 2; d < W; d *= 2) begin
      ng = gg;
      np = pp;
      for (int i = 1; i < W; i += 2) begin
        if (i >= d) begin
          ng[i] = gg[i] | (pp[i] & gg[i-d]);
          np[i] = pp[i] & pp[i-d];
        end
      end
      gg = ng;
      pp = np;
    end
    for (int i = 2; i < W; i += 2) gg[i] = g[i] | (p[i] & gg[i-1]);
    sum[0] = p[0] ^ cin_w;
    for (int i = 1; i < W; i++) sum[i] = p[i] ^ gg[i-1];
    sum[W] = gg[W-1];
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    x_d      = x_q;
    y_d      = y_q;
    id_d     = id_q;
    res_s_d  = res_s_q;
    res_id_d = res_id_q;
`ifdef HCA_ARB_CIN_EN
    cin_d    = cin_q;
`endif
    unique case (state_q)
      S_IDLE: if (gnt_found) begin
        x_d     = x_sel;
        y_d     = y_sel;
        id_d    = gnt_idx;
        ptr_d   = gnt_idx;
`ifdef HCA_ARB_CIN_EN
        cin_d   = cin_sel;
`endif
        state_d = S_CALC;
      end
      S_CALC: begin
        res_s_d  = sum;
        res_id_d = id_q;
        state_d  = S_OUT;
      end
      S_OUT: if (RES_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= S_IDLE;
      ptr_q    <= PW'(NREQ-1);
      x_q      <= '0;
      y_q      <= '0;
      id_q     <= '0;
      res_s_q  <= '0;
      res_id_q <= '0;
`ifdef HCA_ARB_CIN_EN
      cin_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      id_q     <= id_d;
      res_s_q  <= res_s_d;
      res_id_q <= res_id_d;
`ifdef HCA_ARB_CIN_EN
      cin_q    <= cin_d;
`endif
    end
  end

  // Grant is gated by RSTn so VALID cannot leak through while held in reset.
  always_comb begin
    READY = '0;
    if (RSTn && state_q == S_IDLE && gnt_found) READY[gnt_idx] = 1'b1;
  end

  assign RES_VALID = (state_q == S_OUT);
  assign RES_S     = res_s_q;
  assign RES_ID    = res_id_q;

  // cin_sel is only consumed when the carry-in option is built in.
  logic unused_ok;
  assign unused_ok = cin_sel;
endmodule

// File: tb/tb_hca_arb_4x9.sv
module tb_hca_arb_4x9;
  logic        CLK = 1'b0;
  logic        RSTn;
  logic [3:0]  VALID;
  logic [35:0] X, Y;
  logic [3:0]  CIN;
  logic [3:0]  READY;
  logic        RES_VALID, RES_READY;
  logic [9:0]  RES_S;
  logic [1:0]  RES_ID;

  int n_cmp = 0;
  int n_err = 0;

  hca_arb_4x9 dut (
    .CLK(CLK), .RSTn(RSTn), .VALID(VALID), .X(X), .Y(Y),
`ifdef HCA_ARB_CIN_EN
    .CIN(CIN),
`endif
    .READY(READY), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_S(RES_S), .RES_ID(RES_ID)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_op(input int i, input int xv, input int yv);
    X[i*9 +: 9] = 9'(xv);
    Y[i*9 +: 9] = 9'(yv);
  endtask

  int exp_ord [5] = '{0, 1, 2, 3, 0};
  int exp_sum [5] = '{57, 287, 517, 747, 57};

  initial begin
    RSTn = 1'b0; VALID = 4'b1111; X = '0; Y = '0; CIN = '0; RES_READY = 1'b0;
    #3;
    chk("rst_ready",  32'(READY), 0);
    chk("rst_rvalid", 32'(RES_VALID), 0);
    chk("rst_res_s",  32'(RES_S), 0);
    chk("rst_res_id", 32'(RES_ID), 0);
    step(); step();
    VALID = 4'b0000;
    RSTn  = 1'b1;

    // max operands from requester 0 straight after reset
    set_op(0, 511, 511);
    VALID = 4'b0001;
    #1 chk("t1_ready", 32'(READY), 32'b0001);
    step();
    VALID = 4'b0000;
    #1 chk("t1_calc_rv", 32'(RES_VALID), 0);
    chk("t1_calc_ready", 32'(READY), 0);
    step();
    chk("t1_rv", 32'(RES_VALID), 1);
    chk("t1_s",  32'(RES_S), 1022);
    chk("t1_id", 32'(RES_ID), 0);
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;

    // all requesting, consumer always ready: 0,1,2,3,0 every 3 cycles
    RSTn = 1'b0;
    step();
    RSTn = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 100*i + 7, 130*i + 50);
    VALID = 4'b1111; RES_READY = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("t2_gnt%0d", n), 32'(READY), 32'(1 << exp_ord[n]));
      step();
      chk($sformatf("t2_calc%0d", n), 32'(READY), 0);
      step();
      chk($sformatf("t2_rv%0d", n), 32'(RES_VALID), 1);
      chk($sformatf("t2_id%0d", n), 32'(RES_ID), 32'(exp_ord[n]));
      chk($sformatf("t2_s%0d", n),  32'(RES_S), 32'(exp_sum[n]));
      chk($sformatf("t2_out_rdy%0d", n), 32'(READY), 0);
      step();
    end
    VALID = 4'b0000; RES_READY = 1'b0;

    // consumer stalls 5 cycles in OUT while requester 1 keeps asking
    set_op(1, 300, 400);
    VALID = 4'b0010;
    #1 chk("t3_gnt", 32'(READY), 32'b0010);
    step();
    chk("t3_calc_ready", 32'(READY), 0);
    step();
    for (int n = 0; n < 5; n++) begin
      chk($sformatf("t3_rv%0d", n),  32'(RES_VALID), 1);
      chk($sformatf("t3_s%0d", n),   32'(RES_S), 700);
      chk($sformatf("t3_id%0d", n),  32'(RES_ID), 1);
      chk($sformatf("t3_rdy%0d", n), 32'(READY), 0);
      step();
    end
    RES_READY = 1'b1;
    #1 chk("t3_pulse_rdy", 32'(READY), 0);
    step();
    RES_READY = 1'b0;
    #1 chk("t3_regnt", 32'(READY), 32'b0010);
    chk("t3_idle_rv", 32'(RES_VALID), 0);
    step();
    VALID = 4'b0000;
    step();
    chk("t3_s2", 32'(RES_S), 700);
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;

    // reset lands in CALC: operation dropped, pointer back to 3
    set_op(2, 200, 250);
    VALID = 4'b0100;
    #1 chk("t4_gnt", 32'(READY), 32'b0100);
    step();
    VALID = 4'b0000;
    RSTn  = 1'b0;
    #1 chk("t4_rst_rv", 32'(RES_VALID), 0);
    chk("t4_rst_s", 32'(RES_S), 0);
    step();
    RSTn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      chk($sformatf("t4_norv%0d", n), 32'(RES_VALID), 0);
      step();
    end
    VALID = 4'b1111;
    #1 chk("t4_gnt0", 32'(READY), 32'b0001);
    step();
    VALID = 4'b0000;
    step();
    chk("t4_id", 32'(RES_ID), 0);
    chk("t4_s",  32'(RES_S), 57);
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;

    // VALID[3] pulses during CALC only
    set_op(0, 10, 20);
    VALID = 4'b0001;
    #1 chk("t5_gnt", 32'(READY), 32'b0001);
    step();
    VALID = 4'b1000;
    #1 chk("t5_calc_rdy", 32'(READY), 0);
    step();
    VALID = 4'b0000;
    #1 chk("t5_rv", 32'(RES_VALID), 1);
    chk("t5_s",  32'(RES_S), 30);
    chk("t5_id", 32'(RES_ID), 0);
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;
    #1 chk("t5_no_gnt", 32'(READY), 0);
    step();
    chk("t5_no_rv",  32'(RES_VALID), 0);
    chk("t5_hold_s", 32'(RES_S), 30);
    chk("t5_hold_id", 32'(RES_ID), 0);

    // carry-in path on requester 2
    set_op(2, 511, 511);
    CIN   = 4'b0100;
    VALID = 4'b0100;
    #1 chk("t6_gnt", 32'(READY), 32'b0100);
    step();
    VALID = 4'b0000; CIN = 4'b0000;
    step();
    chk("t6_rv", 32'(RES_VALID), 1);
`ifdef HCA_ARB_CIN_EN
    chk("t6_s", 32'(RES_S), 1023);
`else
    chk("t6_s", 32'(RES_S), 1022);
`endif
    chk("t6_id", 32'(RES_ID), 2);
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;
    #1 chk("t6_done_rv", 32'(RES_VALID), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
